// File: rtl/i2c_rst_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// i2c_rst_checker : reset-value checker for I2C controller register channels.
// Optional mismatch counter: define I2C_RSTCHK_COUNT_EN.   Revision: 1.0
// ============================================================================
module i2c_rst_checker #(
  parameter int NCH      = 6,
  parameter int DW       = 16,
  parameter int HOLD_CYC = 4,
  parameter int MIN_RST  = 2,
  parameter int CW       = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   arst_i,
  input  logic                   wb_rst_i,
  input  logic [NCH*DW-1:0]      chk_val_i,
  input  logic [NCH*DW-1:0]      chk_exp_i,
  input  logic [NCH*DW-1:0]      chk_mask_i,
  input  logic                   clr_i,
  output logic [NCH-1:0]         err_o,
  output logic                   err_any_o,
  output logic                   err_short_o,
  output logic [$clog2(NCH):0]   first_ch_o,
  output logic                   first_vld_o,
  output logic [CW-1:0]          err_cnt_o,
  output logic [1:0]             state_o
);

  localparam int FW = $clog2(NCH) + 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int PW = $clog2(MIN_RST + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [PW-1:0] PULSE_MAX = PW'(MIN_RST);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SRST = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nx;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= HOLD;
      hold_cnt <= HOLD_LOAD;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    case (state)
      RUN: begin
        if (wb_rst_i) state_nx = SRST;
      end
      SRST: begin
        if (!wb_rst_i) begin
          state_nx = HOLD;
          hold_nx  = HOLD_LOAD;
        end
      end
      HOLD: begin
        // A re-asserted reset abandons the hold countdown.
        if (wb_rst_i)              state_nx = SRST;
        else if (hold_cnt == '0)   state_nx = RUN;
        else                       hold_nx  = hold_cnt - 1'b1;
      end
      default: begin
        state_nx = HOLD;
        hold_nx  = HOLD_LOAD;
      end
    endcase
  end

  assign state_o = state;

  logic           in_win;
  logic [NCH-1:0] mism;
  logic           mism_any;
  logic [FW-1:0]  low_ch;

  assign in_win = (state != RUN);

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign mism[k] = in_win &&
        (((chk_val_i[k*DW +: DW] ^ chk_exp_i[k*DW +: DW]) & chk_mask_i[k*DW +: DW]) != '0);
    end
  endgenerate

  assign mism_any = |mism;

  always_comb begin
    low_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mism[k]) low_ch = FW'(k);
    end
  end

  logic [PW-1:0] pulse_cnt;
  logic          short_fall;

  assign short_fall = !wb_rst_i && (pulse_cnt != '0) && (pulse_cnt < PULSE_MAX);

  // A new event in the same cycle as clr_i survives the clear.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      err_o       <= '0;
      first_ch_o  <= '0;
      first_vld_o <= 1'b0;
      err_short_o <= 1'b0;
      pulse_cnt   <= '0;
    end else begin
      err_o <= (clr_i ? {NCH{1'b0}} : err_o) | mism;
      if (mism_any && (clr_i || !first_vld_o)) begin
        first_vld_o <= 1'b1;
        first_ch_o  <= low_ch;
      end else if (clr_i) begin
        first_vld_o <= 1'b0;
        first_ch_o  <= '0;
      end
      err_short_o <= (err_short_o && !clr_i) || short_fall;
      if (wb_rst_i) begin
        if (pulse_cnt != PULSE_MAX) pulse_cnt <= pulse_cnt + 1'b1;
      end else begin
        pulse_cnt <= '0;
      end
    end
  end

  assign err_any_o = (|err_o) || err_short_o;

`ifdef I2C_RSTCHK_COUNT_EN
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_q;

  assign cnt_base = clr_i ? {CW{1'b0}} : cnt_q;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else if (mism_any && (cnt_base != {CW{1'b1}})) begin
      cnt_q <= cnt_base + 1'b1;
    end else begin
      cnt_q <= cnt_base;
    end
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_rst_checker.sv
`timescale 1ns/1ps
`default_nettype none
// tb_i2c_rst_checker: directed test-plan scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the checker.
module tb_i2c_rst_checker;

  localparam int NCH      = 6;
  localparam int DW       = 16;
  localparam int HOLD_CYC = 4;
  localparam int MIN_RST  = 2;
  localparam int CW       = 8;
  localparam int FW       = $clog2(NCH) + 1;
  localparam int CNT_MAX  = (1 << CW) - 1;
`ifdef I2C_RSTCHK_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_SRST = 1, M_HOLD = 2;

  logic                clk = 1'b0;
  logic                arst;
  logic                wb;
  logic [NCH*DW-1:0]   val, exp_v, mask;
  logic                clr;
  logic [NCH-1:0]      err;
  logic                err_any, err_short, first_vld;
  logic [FW-1:0]       first_ch;
  logic [CW-1:0]       err_cnt;
  logic [1:0]          state;

  i2c_rst_checker #(
    .NCH(NCH), .DW(DW), .HOLD_CYC(HOLD_CYC), .MIN_RST(MIN_RST), .CW(CW)
  ) dut (
    .wb_clk_i(clk), .arst_i(arst), .wb_rst_i(wb),
    .chk_val_i(val), .chk_exp_i(exp_v), .chk_mask_i(mask), .clr_i(clr),
    .err_o(err), .err_any_o(err_any), .err_short_o(err_short),
    .first_ch_o(first_ch), .first_vld_o(first_vld),
    .err_cnt_o(err_cnt), .state_o(state)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [NCH-1:0] m_err;
  logic           m_short, m_fvld;
  int             m_fch, m_cnt, m_state, m_left, m_run;
  int             n_vec = 0;
  int             n_err = 0;
  bit             check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_err = '0; m_short = 1'b0; m_fvld = 1'b0; m_fch = 0; m_cnt = 0;
    m_state = M_HOLD; m_left = HOLD_CYC; m_run = 0;
  endtask

  task automatic model_step();
    logic [NCH*DW-1:0] x;
    logic [NCH-1:0]    hit;
    int                low;
    if (!arst) return;
    x = (val ^ exp_v) & mask;
    hit = '0;
    low = -1;
    if (m_state != M_RUN) begin
      for (int k = 0; k < NCH; k++) begin
        if (x[k*DW +: DW] != '0) begin
          hit[k] = 1'b1;
          if (low < 0) low = k;
        end
      end
    end
    if (clr) begin
      m_err = '0; m_short = 1'b0; m_fvld = 1'b0; m_fch = 0; m_cnt = 0;
    end
    m_err = m_err | hit;
    if (low >= 0) begin
      if (!m_fvld) begin m_fvld = 1'b1; m_fch = low; end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (wb) m_run++;
    else begin
      if (m_run > 0 && m_run < MIN_RST) m_short = 1'b1;
      m_run = 0;
    end
    case (m_state)
      M_RUN:  if (wb) m_state = M_SRST;
      M_SRST: if (!wb) begin m_state = M_HOLD; m_left = HOLD_CYC; end
      default: begin
        if (wb) m_state = M_SRST;
        else begin
          m_left--;
          if (m_left == 0) m_state = M_RUN;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("err_o",       32'(err),       32'(m_err));
      chk("err_any_o",   32'(err_any),   32'((|m_err) | m_short));
      chk("err_short_o", 32'(err_short), 32'(m_short));
      chk("first_vld_o", 32'(first_vld), 32'(m_fvld));
      chk("first_ch_o",  32'(first_ch),  m_fch);
      chk("err_cnt_o",   32'(err_cnt),   CNT_EN ? m_cnt : 0);
      chk("state_o",     32'(state),     m_state);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx;
    arst = 1'b0; wb = 1'b0; clr = 1'b0;
    exp_v = '0; exp_v[15:0] = 16'hFFFF;
    mask = '1;
    val = exp_v;
    model_reset();
    check_en = 1'b1;
    steps(2);
    chk("lit_rst_state", 32'(state), 2);
    chk("lit_rst_any", 32'(err_any), 0);
    arst = 1'b1;

    // Clean release: HOLD for 4 clocks then RUN.
    steps(3);
    chk("lit_hold_state", 32'(state), 2);
    step();
    chk("lit_run_state", 32'(state), 0);
    chk("lit_clean_any", 32'(err_any), 0);

    // Channel 3 bit 2 wrong on the 2nd HOLD cycle.
    wb = 1'b1; steps(3);
    wb = 1'b0; step();
    step();
    val[3*DW+2] = ~val[3*DW+2];
    step();
    chk("lit_ch3_err", 32'(err), 32'h08);
    chk("lit_ch3_first", 32'(first_ch), 3);
    chk("lit_ch3_vld", 32'(first_vld), 1);
    chk("lit_ch3_cnt", 32'(err_cnt), CNT_EN ? 1 : 0);
    val = exp_v;
    steps(2);
    chk("lit_ch3_run", 32'(state), 0);
    val[3*DW+2] = ~val[3*DW+2];
    steps(2);
    chk("lit_run_err", 32'(err), 32'h08);
    chk("lit_run_cnt", 32'(err_cnt), CNT_EN ? 1 : 0);
    val = exp_v;

    // Channels 1 and 4 together during SRST.
    clr = 1'b1; step(); clr = 1'b0;
    wb = 1'b1; step();
    val[1*DW+0] = ~val[1*DW+0];
    val[4*DW+15] = ~val[4*DW+15];
    step();
    chk("lit_ch14_err", 32'(err), 32'h12);
    chk("lit_ch14_first", 32'(first_ch), 1);
    chk("lit_ch14_cnt1", 32'(err_cnt), CNT_EN ? 1 : 0);
    steps(2);
    chk("lit_ch14_cnt3", 32'(err_cnt), CNT_EN ? 3 : 0);
    val = exp_v;
    wb = 1'b0; steps(5);

    // Short and legal reset pulses.
    clr = 1'b1; step(); clr = 1'b0;
    wb = 1'b1; step();
    wb = 1'b0; step();
    chk("lit_short_set", 32'(err_short), 1);
    chk("lit_short_any", 32'(err_any), 1);
    steps(4);
    clr = 1'b1; step(); clr = 1'b0;
    wb = 1'b1; steps(2);
    wb = 1'b0; step();
    chk("lit_short_clear", 32'(err_short), 0);
    steps(4);

    // clr_i coincident with a channel 5 mismatch.
    wb = 1'b1; step();
    val[0*DW+7] = ~val[0*DW+7];
    step();
    chk("lit_ch0_err", 32'(err), 32'h01);
    val = exp_v;
    val[5*DW+0] = ~val[5*DW+0];
    clr = 1'b1; step(); clr = 1'b0;
    chk("lit_clr5_err", 32'(err), 32'h20);
    chk("lit_clr5_first", 32'(first_ch), 5);
    chk("lit_clr5_cnt", 32'(err_cnt), CNT_EN ? 1 : 0);
    val = exp_v;
    wb = 1'b0; step();

    // Reset re-asserted on the 2nd HOLD cycle, then a full HOLD.
    step();
    wb = 1'b1; step();
    chk("lit_rehold_srst", 32'(state), 1);
    step();
    wb = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_full_hold", 32'(state), 2);
    end
    step();
    chk("lit_full_run", 32'(state), 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        for (int k = 0; k < NCH; k++) exp_v[k*DW +: DW] = DW'($urandom);
      end
      if (c % 100 == 0) begin
        for (int k = 0; k < NCH; k++)
          mask[k*DW +: DW] = ($urandom_range(0, 1) == 0) ? '1 : DW'($urandom);
      end
      val = exp_v;
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, NCH*DW-1);
        val[idx] = ~val[idx];
        if ($urandom_range(0, 2) == 0) begin
          idx = $urandom_range(0, NCH*DW-1);
          val[idx] = ~val[idx];
        end
      end
      if ($urandom_range(0, 99) < (wb ? 35 : 12)) wb = ~wb;
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 399) == 0) begin
        arst = 1'b0;
        model_reset();
        steps(2);
        arst = 1'b1;
      end
      step();
    end

    clr = 1'b0; wb = 1'b0;
    steps(2);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
